// File: rtl/systolic_array_pkg.sv
// rtl/systolic_array_pkg.sv - shared types, default sizes and helpers for the systolic tile
package systolic_array_pkg;

  localparam int SA_ROWS  = 4;
  localparam int SA_COLS  = 4;
  localparam int SA_DW    = 16;
  localparam int SA_ACC_W = 40;
  localparam int SA_KW    = 8;

  typedef logic signed [SA_DW-1:0]    word_t;
  typedef logic signed [SA_ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } sa_state_e;

  // Zero-operand cycles needed for the last beat to cross the whole skewed array
  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// rtl/sa_mac_pe.sv - one MAC processing element; SYSTOLIC_ACC_SAT_EN selects saturating accumulate
module sa_mac_pe
  import systolic_array_pkg::*;
#(
  parameter int DW    = SA_DW,
  parameter int ACC_W = SA_ACC_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  logic                    clear_acc,
  input  logic                    clear_pipe,
  input  logic signed [DW-1:0]    x_in,
  input  logic signed [DW-1:0]    w_in,
  output logic signed [DW-1:0]    x_out,
  output logic signed [DW-1:0]    w_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_next;

  assign prod = (2*DW)'(x_in) * (2*DW)'(w_in);

`ifdef SYSTOLIC_ACC_SAT_EN
  // One guard bit catches overflow; clamp toward the sign of the true sum
  logic signed [ACC_W:0] sum;
  assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);

  // Saturating accumulate
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = acc + ACC_W'(prod);
`endif

  // Accumulator and forwarding registers; clear wins over advance
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc   <= '0;
      x_out <= '0;
      w_out <= '0;
    end else begin
      if (clear_acc) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc_next;
      end
      if (clear_pipe) begin
        x_out <= '0;
        w_out <= '0;
      end else if (en) begin
        x_out <= x_in;
        w_out <= w_in;
      end
    end
  end

endmodule

// File: rtl/systolic_array_tile.sv
// rtl/systolic_array_tile.sv - output-stationary systolic matmul tile; PEs honour SYSTOLIC_ACC_SAT_EN
module systolic_array_tile
  import systolic_array_pkg::*;
#(
  parameter int ROWS  = SA_ROWS,
  parameter int COLS  = SA_COLS,
  parameter int DW    = SA_DW,
  parameter int ACC_W = SA_ACC_W,
  parameter int KW    = SA_KW,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  accum,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*DW-1:0]    x_in,
  input  logic [COLS*DW-1:0]    w_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] y_out,
  output logic [ROW_W-1:0]      out_row,
  output logic                  busy,
  output logic                  done
);

  localparam int FLUSH_N = flush_cycles(ROWS, COLS);
  localparam int FW      = $clog2(FLUSH_N + 1);

  sa_state_e      state;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  k_cnt;
  logic [FW-1:0]  f_cnt;

  logic job_start;
  logic adv;
  logic clear_acc;

  // Array moves only on an accepted beat while loading, and every cycle while flushing
  assign job_start = (state == IDLE) && start;
  assign clear_acc = job_start && !accum;
  assign adv       = ((state == LOAD) && in_valid) || (state == FLUSH);

  logic signed [DW-1:0]    x_h [ROWS][COLS+1];
  logic signed [DW-1:0]    w_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0] acc_q [ROWS][COLS];
  logic [COLS*ACC_W-1:0]   row_acc [ROWS];
  logic [ROWS*DW+COLS*DW-1:0] unused_edge;

  // X skew: lane r enters the array r advances late
  for (genvar r = 0; r < ROWS; r++) begin : g_xskew
    logic signed [DW-1:0] lane;
    assign lane = (state == LOAD) ? x_in[r*DW +: DW] : '0;
    if (r == 0) begin : g_direct
      assign x_h[r][0] = lane;
    end else begin : g_delay
      logic signed [DW-1:0] sr [r];
      // Advance-gated delay line, cleared at job start
      always_ff @(posedge clk) begin
        if (!n_rst || job_start) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= lane;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign x_h[r][0] = sr[r-1];
    end
    assign unused_edge[r*DW +: DW] = x_h[r][COLS];
  end

  // W skew: lane c enters the array c advances late
  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    logic signed [DW-1:0] lane;
    assign lane = (state == LOAD) ? w_in[c*DW +: DW] : '0;
    if (c == 0) begin : g_direct
      assign w_v[0][c] = lane;
    end else begin : g_delay
      logic signed [DW-1:0] sr [c];
      // Advance-gated delay line, cleared at job start
      always_ff @(posedge clk) begin
        if (!n_rst || job_start) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= lane;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign w_v[0][c] = sr[c-1];
    end
    assign unused_edge[ROWS*DW + c*DW +: DW] = w_v[ROWS][c];
  end

  // PE grid: x flows right, w flows down
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_mac_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (adv),
        .clear_acc  (clear_acc),
        .clear_pipe (job_start),
        .x_in       (x_h[r][c]),
        .w_in       (w_v[r][c]),
        .x_out      (x_h[r][c+1]),
        .w_out      (w_v[r+1][c]),
        .acc        (acc_q[r][c])
      );
      assign row_acc[r][c*ACC_W +: ACC_W] = acc_q[r][c];
    end
  end

  // Drain mux; zero whenever no row is being presented
  assign y_out = out_valid ? row_acc[out_row] : '0;

  // Job sequencer with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      k_cnt     <= '0;
      f_cnt     <= '0;
      out_row   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_reg <= k_len;
            k_cnt <= '0;
            busy  <= 1'b1;
            if (k_len == '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (k_cnt == k_reg - KW'(1)) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
              f_cnt    <= '0;
            end else begin
              k_cnt <= k_cnt + KW'(1);
            end
          end
        end
        FLUSH: begin
          if (f_cnt == FW'(FLUSH_N - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else begin
            f_cnt <= f_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row == ROW_W'(ROWS - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_row   <= '0;
            end else begin
              out_row <= out_row + ROW_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_tile.sv
// tb/tb_systolic_array_tile.sv - directed self-checking bench for systolic_array_tile (2x2, 32-bit acc)
module tb_systolic_array_tile;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        accum;
  logic [7:0]  k_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y_out;
  logic [0:0]  out_row;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  // X = [[1,2],[3,4]] by columns, W = [[5,6],[7,8]] by rows; beat k at [k*32 +: 32], lane 0 low
  localparam logic [95:0] XB = {32'd0, 16'd4, 16'd2, 16'd3, 16'd1};
  localparam logic [95:0] WB = {32'd0, 16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [63:0] Y0 = {32'd22, 32'd19};
  localparam logic [63:0] Y1 = {32'd50, 32'd43};
  localparam logic [63:0] Y0_ACC = {32'd44, 32'd38};
  localparam logic [63:0] Y1_ACC = {32'd100, 32'd86};
  localparam logic [95:0] NEG_B = {3{32'h8000_8000}};
`ifdef SYSTOLIC_ACC_SAT_EN
  localparam logic [31:0] BIG = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] BIG = 32'hC000_0000;
`endif

  systolic_array_tile #(
    .ROWS  (2),
    .COLS  (2),
    .DW    (16),
    .ACC_W (32),
    .KW    (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .accum     (accum),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .out_row   (out_row),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy, done, out_row} !== 5'b0 || y_out !== 64'd0) begin
      miscompares++;
      $display("FAIL reset: ir/ov/busy/done/row=%b y=%h, expected 00000 y=0",
               {in_ready, out_valid, busy, done, out_row}, y_out);
    end
    n_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  // Starts at a negedge, ends at the negedge where done should be high
  task automatic run_job(input string name, input logic acc_mode, input int kk,
                         input logic [95:0] xb, input logic [95:0] wb,
                         input int gap, input int hold,
                         input logic [63:0] exp0, input logic [63:0] exp1);
    int cyc;
    int exp_cyc;
    logic exp_ir;
    start = 1'b1;
    accum = acc_mode;
    k_len = kk[7:0];
    @(negedge clk);
    start = 1'b0;
    exp_ir = (kk > 0);
    vectors++;
    if (in_ready !== exp_ir || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s entry: in_ready=%b busy=%b done=%b, expected %b 1 0",
               name, in_ready, busy, done, exp_ir);
    end
    for (int k = 0; k < kk; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s stall: in_ready=%b out_valid=%b, expected 1 0", name, in_ready, out_valid);
        end
      end
      in_valid = 1'b1;
      x_in = xb[k*32 +: 32];
      w_in = wb[k*32 +: 32];
      @(negedge clk);
    end
    in_valid = 1'b0;
    x_in = '0;
    w_in = '0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s flush_ready: in_ready=%b, expected 0", name, in_ready);
      end
      @(negedge clk);
      cyc++;
    end
    exp_cyc = (kk == 0) ? 1 : 4;
    vectors++;
    if (cyc !== exp_cyc) begin
      miscompares++;
      $display("FAIL %s latency: first out_valid after %0d edges, expected %0d", name, cyc, exp_cyc);
    end
    for (int h = 0; h < hold; h++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_row !== 1'b0 || y_out !== exp0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold: ov=%b row=%b y=%h done=%b, expected 1 0 %h 0",
                 name, out_valid, out_row, y_out, done, exp0);
      end
      @(negedge clk);
    end
    vectors++;
    if (out_row !== 1'b0 || y_out !== exp0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s row0: row=%b y=%h ir=%b, expected 0 %h 0", name, out_row, y_out, in_ready, exp0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_row !== 1'b1 || y_out !== exp1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s row1: ov=%b row=%b y=%h done=%b, expected 1 1 %h 0",
               name, out_valid, out_row, y_out, done, exp1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_row !== 1'b0 || y_out !== 64'd0) begin
      miscompares++;
      $display("FAIL %s done: done=%b busy=%b ov=%b row=%b y=%h, expected 1 0 0 0 0",
               name, done, busy, out_valid, out_row, y_out);
    end
  endtask

  task automatic test_reset_mid_flush;
    start = 1'b1;
    accum = 1'b0;
    k_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      x_in = XB[k*32 +: 32];
      w_in = WB[k*32 +: 32];
      @(negedge clk);
    end
    in_valid = 1'b0;
    x_in = '0;
    w_in = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_flush: busy=%b ov=%b ir=%b, expected 1 0 0", busy, out_valid, in_ready);
    end
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || y_out !== 64'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: busy=%b ov=%b y=%h ir=%b done=%b, expected 0 0 0 0 0",
               busy, out_valid, y_out, in_ready, done);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
    run_job("kzero", 1'b1, 0, '0, '0, 0, 0, 64'd0, 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n_rst = 1'b0;
    start = 1'b0;
    accum = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    x_in = '0;
    w_in = '0;
    out_ready = 1'b0;
    test_reset();
    run_job("basic_hold", 1'b0, 2, XB, WB, 0, 5, Y0, Y1);
    run_job("gapped", 1'b0, 2, XB, WB, 3, 0, Y0, Y1);
    run_job("accum", 1'b1, 2, XB, WB, 0, 0, Y0_ACC, Y1_ACC);
    run_job("reclear", 1'b0, 2, XB, WB, 0, 0, Y0, Y1);
    run_job("extreme", 1'b0, 3, NEG_B, NEG_B, 0, 0, {BIG, BIG}, {BIG, BIG});
    test_reset_mid_flush();
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_once: done=%b busy=%b, expected 0 0", done, busy);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
